tmr_rx_voter: RTL and testbench
===============================

TMR_RX_VOTER -- requirements
Module: tmr_rx_voter

Interface
REQ-001 Parameter NCH, default 3: number of redundant receive channels; odd, 3..7.
REQ-002 Parameter CMD_L, default 4: command field width; frame width DATA_L = 2 + 3*CMD_L (14 at default), derived, not overridable.
REQ-003 Parameter WIN, default 1024: collection window length in clk cycles after the first channel arrival.
REQ-004 Parameter TIMEOUT, default 5_000_000: clk cycles without an accepted frame before link loss is declared.
REQ-005 clk  in  1  system clock; the only clock.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 avl  in  NCH  per-channel one-cycle strobe: word on data valid.
REQ-008 data  in  NCH*DATA_L  channel words packed, channel i at [i*DATA_L +: DATA_L].
REQ-009 mode  out  2  voted mode.
REQ-010 speed_cmd  out  CMD_L  voted speed command.
REQ-011 dir_cmd  out  CMD_L  voted direction command.
REQ-012 frame_ok  out  1  one-cycle pulse when outputs are updated.
REQ-013 ch_fault  out  NCH  per-channel fault flags from the last evaluated frame.
REQ-014 err_rate  out  4  bad-frame count over the last 15 evaluated frames.
REQ-015 link_lost  out  1  watchdog expired.

Function
REQ-016 Frame format SHALL be [DATA_L-1:DATA_L-2] mode, next CMD_L speed, next CMD_L dir, low CMD_L checksum = speed ^ dir ^ zero-extended mode.
REQ-017 FSM states SHALL be IDLE, COLLECT, VOTE; IDLE -> COLLECT on any avl bit, latching every strobing channel's word that cycle.
REQ-018 In COLLECT each channel's first strobe SHALL be latched; repeat strobes from an already-latched channel SHALL be ignored.
REQ-019 COLLECT -> VOTE when all NCH channels are latched or the window counter reaches WIN-1, whichever is first.
REQ-020 VOTE SHALL last exactly one cycle, then return to IDLE; avl during VOTE SHALL be ignored.
REQ-021 Vote SHALL be bitwise: bit = 1 iff 2*ones > received count, computed over latched channels only.
REQ-022 Quorum SHALL be received count >= NCH/2+1; quorum failure or checksum mismatch marks the frame bad.
REQ-023 Good frame: mode/speed_cmd/dir_cmd SHALL update and frame_ok SHALL pulse on the clk edge leaving VOTE (latency: one cycle after COLLECT ends).
REQ-024 Bad frame: outputs SHALL hold, frame_ok SHALL stay low.
REQ-025 ch_fault[i] SHALL be set on each evaluated frame iff channel i was not latched or its word differs from the voted word, and held until the next evaluation.
REQ-026 A 15-bit history SHALL shift in 1 for bad, 0 for good per evaluated frame; err_rate = popcount (0..15, no overflow).
REQ-027 Watchdog counter SHALL clear on every good frame, else increment; at TIMEOUT it SHALL saturate, assert link_lost, force mode=0, speed_cmd=0, dir_cmd=0.
REQ-028 link_lost SHALL clear on the same edge as the next good frame's output update.
REQ-029 Good frame and watchdog expiry on the same edge: good frame wins.

Reset
REQ-030 rst low SHALL immediately force IDLE, clear latches, counters and history, and drive all outputs to 0 (link_lost=0), including mid-frame.
REQ-031 After rst release, a frame in progress on the channels SHALL be treated as new (no partial state retained).

Structure
REQ-032 Shared package SHALL hold the FSM state encoding, frame field offsets and the checksum function.
REQ-033 One sub-module, tmr_bit_vote (NCH words + latched mask -> voted word, received count, per-channel mismatch), SHALL be instantiated once.

Verification
REQ-034 NCH=3, all channels same word mode=2,speed=5,dir=9,chk=0xE within 10 cycles -> frame_ok once, outputs 2/5/9, ch_fault=000, err_rate 0.
REQ-035 Channel 1 speed bit corrupted (speed=4, chk unchanged) -> outputs 2/5/9, ch_fault=010, frame counted good.
REQ-036 Only channel 0 strobes, window expires at WIN -> no frame_ok, outputs hold, ch_fault=110, err_rate increments by 1.
REQ-037 All channels send bad checksum 15 times then good frames 15 times -> err_rate rises to 15 then decays to 0.
REQ-038 No good frame for TIMEOUT cycles -> link_lost=1, mode/speed/dir=0; next good frame -> link_lost=0 with new values same edge.
REQ-039 rst asserted mid-COLLECT -> all outputs 0 at once; after release, next full frame accepted normally.

Source files
------------

// File: rtl/tmr_rx_voter_pkg.sv
// rtl/tmr_rx_voter_pkg.sv - shared state encoding, frame field offsets and checksum for the TMR receive voter
package tmr_rx_voter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VOTE    = 2'd2
  } state_t;

  localparam int MODE_W    = 2;
  localparam int MAX_CMD_L = 16;

  // Frame layout, MSB to LSB: mode | speed | dir | checksum
  function automatic int frame_len(input int cmd_l);
    return MODE_W + 3 * cmd_l;
  endfunction

  function automatic int chk_lsb(input int cmd_l);
    return 0 * cmd_l;
  endfunction

  function automatic int dir_lsb(input int cmd_l);
    return cmd_l;
  endfunction

  function automatic int speed_lsb(input int cmd_l);
    return 2 * cmd_l;
  endfunction

  function automatic int mode_lsb(input int cmd_l);
    return 3 * cmd_l;
  endfunction

  // Callers zero-extend speed/dir to MAX_CMD_L, so the upper result bits are zero
  function automatic logic [MAX_CMD_L-1:0] calc_chk(input logic [MODE_W-1:0]    mode,
                                                     input logic [MAX_CMD_L-1:0] speed,
                                                     input logic [MAX_CMD_L-1:0] dir);
    return speed ^ dir ^ {{(MAX_CMD_L-MODE_W){1'b0}}, mode};
  endfunction

endpackage

// File: rtl/tmr_bit_vote.sv
// rtl/tmr_bit_vote.sv - bitwise majority vote over the latched subset of channel words
module tmr_bit_vote #(
  parameter int NCH = 3,
  parameter int W   = 14,
  parameter int CW  = $clog2(NCH + 1)
) (
  input  logic [NCH*W-1:0] i_words,
  input  logic [NCH-1:0]   i_mask,
  output logic [W-1:0]     o_voted,
  output logic [CW-1:0]    o_count,
  output logic [NCH-1:0]   o_mismatch
);

  logic [CW-1:0] w_count;
  logic [W-1:0]  w_voted;

  // Count latched channels, then set each bit where ones form a strict majority of them
  always_comb begin
    logic [CW-1:0] ones;
    w_count = '0;
    w_voted = '0;
    for (int i = 0; i < NCH; i++) begin
      w_count = w_count + CW'(i_mask[i]);
    end
    for (int b = 0; b < W; b++) begin
      ones = '0;
      for (int i = 0; i < NCH; i++) begin
        ones = ones + CW'(i_mask[i] & i_words[i*W + b]);
      end
      w_voted[b] = ({ones, 1'b0} > {1'b0, w_count});
    end
  end

  // A latched channel disagrees if its word differs anywhere from the voted word
  always_comb begin
    o_mismatch = '0;
    for (int i = 0; i < NCH; i++) begin
      o_mismatch[i] = i_mask[i] && (i_words[i*W +: W] != w_voted);
    end
  end

  assign o_voted = w_voted;
  assign o_count = w_count;

endmodule

// File: rtl/tmr_rx_voter.sv
// rtl/tmr_rx_voter.sv - collects redundant command frames, votes them, tracks error rate and link watchdog
module tmr_rx_voter
  import tmr_rx_voter_pkg::*;
#(
  parameter  int NCH     = 3,
  parameter  int CMD_L   = 4,
  parameter  int WIN     = 1024,
  parameter  int TIMEOUT = 5_000_000,
  localparam int DATA_L  = frame_len(CMD_L)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH-1:0]        avl,
  input  logic [NCH*DATA_L-1:0] data,
  output logic [MODE_W-1:0]     mode,
  output logic [CMD_L-1:0]      speed_cmd,
  output logic [CMD_L-1:0]      dir_cmd,
  output logic                  frame_ok,
  output logic [NCH-1:0]        ch_fault,
  output logic [3:0]            err_rate,
  output logic                  link_lost
);

  localparam int CW      = $clog2(NCH + 1);
  localparam int WCW     = $clog2(WIN);
  localparam int TW      = $clog2(TIMEOUT + 1);
  localparam int MODE_LO = mode_lsb(CMD_L);
  localparam int SPD_LO  = speed_lsb(CMD_L);
  localparam int DIR_LO  = dir_lsb(CMD_L);
  localparam int CHK_LO  = chk_lsb(CMD_L);
  localparam logic [CW-1:0]  QUORUM   = CW'(NCH / 2 + 1);
  localparam logic [WCW-1:0] WIN_LAST = WCW'(WIN - 1);
  localparam logic [TW-1:0]  WD_MAX   = TW'(TIMEOUT);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [NCH-1:0]        w_cap;
  logic [NCH-1:0]        r_mask;
  logic [NCH*DATA_L-1:0] r_words;
  logic [WCW-1:0]        r_win;

  logic [MODE_W-1:0]     r_mode;
  logic [CMD_L-1:0]      r_speed;
  logic [CMD_L-1:0]      r_dir;
  logic                  r_frame_ok;
  logic [NCH-1:0]        r_fault;
  logic [14:0]           r_hist;
  logic [TW-1:0]         r_wdog;
  logic                  r_lost;

  logic [DATA_L-1:0]     w_voted;
  logic [CW-1:0]         w_count;
  logic [NCH-1:0]        w_mismatch;
  logic                  w_eval;
  logic                  w_chk_ok;
  logic                  w_frame_good;
  logic                  w_good;
  logic [TW-1:0]         w_wd_nxt;
  logic [3:0]            w_err;

  tmr_bit_vote #(
    .NCH (NCH),
    .W   (DATA_L),
    .CW  (CW)
  ) u_vote (
    .i_words    (r_words),
    .i_mask     (r_mask),
    .o_voted    (w_voted),
    .o_count    (w_count),
    .o_mismatch (w_mismatch)
  );

  // Frame sequencing: pick which strobes to capture and when collection ends
  always_comb begin
    w_state_nxt = r_state;
    w_cap       = '0;
    case (r_state)
      ST_IDLE: begin
        if (|avl) begin
          w_cap       = avl;
          w_state_nxt = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        w_cap = avl & ~r_mask;
        if ((&(r_mask | avl)) || (r_win == WIN_LAST)) begin
          w_state_nxt = ST_VOTE;
        end
      end
      ST_VOTE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register, capture mask, latched words and collection window counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_mask  <= '0;
      r_words <= '0;
      r_win   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mask  <= (r_state == ST_IDLE) ? w_cap : (r_mask | w_cap);
      r_win   <= (r_state == ST_COLLECT) ? (r_win + WCW'(1)) : '0;
      for (int i = 0; i < NCH; i++) begin
        if (w_cap[i]) begin
          r_words[i*DATA_L +: DATA_L] <= data[i*DATA_L +: DATA_L];
        end
      end
    end
  end

  assign w_eval       = (r_state == ST_VOTE);
  assign w_chk_ok     = calc_chk(w_voted[MODE_LO +: MODE_W],
                                 MAX_CMD_L'(w_voted[SPD_LO +: CMD_L]),
                                 MAX_CMD_L'(w_voted[DIR_LO +: CMD_L]))
                        == MAX_CMD_L'(w_voted[CHK_LO +: CMD_L]);
  assign w_frame_good = (w_count >= QUORUM) && w_chk_ok;
  assign w_good       = w_eval && w_frame_good;
  assign w_wd_nxt     = (r_wdog == WD_MAX) ? r_wdog : (r_wdog + TW'(1));

  // Output update, fault/history bookkeeping and watchdog; a good frame beats expiry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode     <= '0;
      r_speed    <= '0;
      r_dir      <= '0;
      r_frame_ok <= 1'b0;
      r_fault    <= '0;
      r_hist     <= '0;
      r_wdog     <= '0;
      r_lost     <= 1'b0;
    end else begin
      r_frame_ok <= w_good;
      if (w_eval) begin
        r_fault <= ~r_mask | w_mismatch;
        r_hist  <= {r_hist[13:0], ~w_frame_good};
      end
      if (w_good) begin
        r_mode  <= w_voted[MODE_LO +: MODE_W];
        r_speed <= w_voted[SPD_LO +: CMD_L];
        r_dir   <= w_voted[DIR_LO +: CMD_L];
        r_wdog  <= '0;
        r_lost  <= 1'b0;
      end else begin
        r_wdog <= w_wd_nxt;
        if (w_wd_nxt == WD_MAX) begin
          r_lost  <= 1'b1;
          r_mode  <= '0;
          r_speed <= '0;
          r_dir   <= '0;
        end
      end
    end
  end

  // Bad frames among the last fifteen evaluations
  always_comb begin
    w_err = '0;
    for (int i = 0; i < 15; i++) begin
      w_err = w_err + 4'(r_hist[i]);
    end
  end

  assign mode      = r_mode;
  assign speed_cmd = r_speed;
  assign dir_cmd   = r_dir;
  assign frame_ok  = r_frame_ok;
  assign ch_fault  = r_fault;
  assign err_rate  = w_err;
  assign link_lost = r_lost;

endmodule

// File: tb/tb_tmr_rx_voter.sv
// tb/tb_tmr_rx_voter.sv - directed scoreboard bench for tmr_rx_voter
module tb_tmr_rx_voter;

  localparam int NCH     = 3;
  localparam int CMD_L   = 4;
  localparam int DL      = 14;
  localparam int WIN     = 16;
  localparam int TIMEOUT = 200;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    avl;
  logic [NCH*DL-1:0] data;
  logic [1:0]        mode;
  logic [3:0]        speed_cmd;
  logic [3:0]        dir_cmd;
  logic              frame_ok;
  logic [NCH-1:0]    ch_fault;
  logic [3:0]        err_rate;
  logic              link_lost;

  int checks   = 0;
  int errors   = 0;
  int n_frames = 0;
  logic [9:0] exp_q[$];
  logic [9:0] mon_e;

  always #5 clk = ~clk;

  tmr_rx_voter #(
    .NCH     (NCH),
    .CMD_L   (CMD_L),
    .WIN     (WIN),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .avl       (avl),
    .data      (data),
    .mode      (mode),
    .speed_cmd (speed_cmd),
    .dir_cmd   (dir_cmd),
    .frame_ok  (frame_ok),
    .ch_fault  (ch_fault),
    .err_rate  (err_rate),
    .link_lost (link_lost)
  );

  function automatic logic [DL-1:0] mk(input logic [1:0] m, input logic [3:0] s,
                                       input logic [3:0] d, input logic bad);
    logic [3:0] c;
    c = s ^ d ^ {2'b00, m};
    if (bad) c = ~c;
    return {m, s, d, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_all(input logic [DL-1:0] w);
    data = {w, w, w};
    avl  = 3'b111;
    tick();
    avl  = 3'b000;
    repeat (3) tick();
  endtask

  task automatic strobe(input int ch, input logic [DL-1:0] w);
    data[ch*DL +: DL] = w;
    avl = 3'b000;
    avl[ch] = 1'b1;
    tick();
    avl = 3'b000;
  endtask

  // Scoreboard: every frame_ok pulse consumes the oldest expected frame
  always @(negedge clk) begin
    if (rst === 1'b1 && frame_ok === 1'b1) begin
      n_frames++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL unexpected_frame_ok: observed %0h/%0h/%0h expected no frame", mode, speed_cmd, dir_cmd);
      end else begin
        mon_e = exp_q.pop_front();
        assert ({mode, speed_cmd, dir_cmd, link_lost} === {mon_e, 1'b0}) else begin
          errors++;
          $error("FAIL frame_outputs: observed %0h expected %0h", {mode, speed_cmd, dir_cmd, link_lost}, {mon_e, 1'b0});
        end
      end
    end
  end

  initial begin
    logic [DL-1:0] w;
    logic [DL-1:0] w2;
    logic [1:0]    m;
    logic [3:0]    s;
    logic [3:0]    d;

    rst  = 1'b0;
    avl  = '0;
    data = '0;
    repeat (3) tick();
    chk("reset_outputs", {mode, speed_cmd, dir_cmd, frame_ok, ch_fault, err_rate, link_lost}, 0);
    rst = 1'b1;
    tick();

    // All three channels agree
    w = mk(2'd2, 4'd5, 4'd9, 1'b0);
    exp_q.push_back({2'd2, 4'd5, 4'd9});
    send_all(w);
    chk("basic_frames", n_frames, 1);
    chk("basic_outputs", {mode, speed_cmd, dir_cmd}, {2'd2, 4'd5, 4'd9});
    chk("basic_fault", ch_fault, 3'b000);
    chk("basic_err", err_rate, 0);

    // Staggered arrival with a repeat strobe on channel 0 that must be ignored
    w2 = mk(2'd1, 4'd3, 4'hC, 1'b0);
    exp_q.push_back({2'd1, 4'd3, 4'hC});
    strobe(0, w2);
    tick();
    strobe(0, mk(2'd3, 4'hF, 4'hF, 1'b1));
    strobe(1, w2);
    strobe(2, w2);
    repeat (3) tick();
    chk("stagger_frames", n_frames, 2);
    chk("stagger_outputs", {mode, speed_cmd, dir_cmd}, {2'd1, 4'd3, 4'hC});
    chk("stagger_fault", ch_fault, 3'b000);

    // Channel 1 speed bit flipped, checksum unchanged
    data = {w, w ^ 14'h0100, w};
    exp_q.push_back({2'd2, 4'd5, 4'd9});
    avl = 3'b111;
    tick();
    avl = 3'b000;
    repeat (3) tick();
    chk("corrupt_frames", n_frames, 3);
    chk("corrupt_outputs", {mode, speed_cmd, dir_cmd}, {2'd2, 4'd5, 4'd9});
    chk("corrupt_fault", ch_fault, 3'b010);
    chk("corrupt_err", err_rate, 0);

    // Single channel only: window expiry, no quorum
    strobe(0, mk(2'd3, 4'd1, 4'd1, 1'b0));
    repeat (WIN) tick();
    chk("window_not_yet", ch_fault, 3'b010);
    tick();
    chk("window_fault", ch_fault, 3'b110);
    chk("window_err", err_rate, 1);
    tick();
    chk("window_frames", n_frames, 3);
    chk("window_hold", {mode, speed_cmd, dir_cmd}, {2'd2, 4'd5, 4'd9});

    // Fifteen bad-checksum frames, then fifteen good frames
    for (int k = 0; k < 15; k++) begin
      m = 2'($urandom_range(0, 3));
      s = 4'($urandom_range(0, 15));
      d = 4'($urandom_range(0, 15));
      send_all(mk(m, s, d, 1'b1));
    end
    chk("err_saturate", err_rate, 15);
    chk("err_no_frame", n_frames, 3);
    for (int k = 0; k < 15; k++) begin
      m = 2'($urandom_range(0, 3));
      s = 4'($urandom_range(0, 15));
      d = 4'($urandom_range(0, 15));
      exp_q.push_back({m, s, d});
      send_all(mk(m, s, d, 1'b0));
      if (k == 6) chk("err_decay_mid", err_rate, 8);
    end
    chk("err_decay_zero", err_rate, 0);
    chk("decay_frames", n_frames, 18);

    // Watchdog expiry, then recovery on the next good frame
    repeat (TIMEOUT - 20) tick();
    chk("wdog_before", link_lost, 1'b0);
    repeat (40) tick();
    chk("wdog_lost", link_lost, 1'b1);
    chk("wdog_zero", {mode, speed_cmd, dir_cmd}, 10'd0);
    exp_q.push_back({2'd1, 4'hA, 4'd3});
    send_all(mk(2'd1, 4'hA, 4'd3, 1'b0));
    chk("wdog_recover", {link_lost, mode, speed_cmd, dir_cmd}, {1'b0, 2'd1, 4'hA, 4'd3});

    // Reset mid-collection clears everything immediately
    strobe(0, mk(2'd3, 4'd7, 4'd2, 1'b0));
    tick();
    rst = 1'b0;
    #1;
    chk("midrst_outputs", {mode, speed_cmd, dir_cmd, frame_ok, ch_fault, err_rate, link_lost}, 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    exp_q.push_back({2'd3, 4'd7, 4'd2});
    send_all(mk(2'd3, 4'd7, 4'd2, 1'b0));
    chk("midrst_frame", {mode, speed_cmd, dir_cmd}, {2'd3, 4'd7, 4'd2});
    chk("midrst_fault", ch_fault, 3'b000);
    chk("midrst_err", err_rate, 0);

    chk("total_frames", n_frames, 20);
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
